// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART-side state encodings, character codes and requester slots
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } arb_state_t;

    localparam int CLKS_PER_BIT = 10417;

    localparam logic [7:0] CHAR_START    = 8'h53;
    localparam logic [7:0] CHAR_HIT      = 8'h48;
    localparam logic [7:0] CHAR_GAMEOVER = 8'h52;
    localparam logic [7:0] CHAR_DIGIT0   = 8'h30;

    localparam int REQ_MOLE     = 0;
    localparam int REQ_GAMEOVER = 1;
    localparam int REQ_SCORE    = 2;
    localparam int REQ_DEBUG    = 3;

    function automatic logic [7:0] digit_char(input logic [3:0] digit);
        return CHAR_DIGIT0 + {4'd0, digit};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - producer requests and uart_tx handshake seen by the arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic                 tx_busy;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic [2:0]           grant_id;
    logic [NUM_REQ-1:0]   pending;
    logic                 sent;
    logic                 overrun;
    logic                 tx_timeout;

    // master is the arbiter itself; slave is the producers plus uart_tx side
    modport master (
        input  req, req_data, tx_busy,
        output tx_start, tx_data, grant_id, pending, sent, overrun, tx_timeout
    );

    modport slave (
        output req, req_data, tx_busy,
        input  tx_start, tx_data, grant_id, pending, sent, overrun, tx_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - round-robin pick of the first pending slot after the last grant
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [2:0]         last,
    output logic               found,
    output logic [2:0]         next
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0] idx;

    always_comb begin
        found = 1'b0;
        next  = 3'd0;
        idx   = '0;
        // k runs to NUM_REQ so the last-granted slot itself is considered last
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last) + k) % NUM_REQ);
            if (!found && pending[idx]) begin
                found = 1'b1;
                next  = 3'(idx);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - latches one-cycle byte requests and feeds them round-robin to uart_tx
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int BUSY_WAIT_MAX = 16
) (
    input  logic              clock,
    input  logic              reset,
    uart_tx_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(BUSY_WAIT_MAX + 1);

    arb_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         last_q;
    logic [7:0]         hold_q [NUM_REQ];
    logic [NUM_REQ-1:0] pending_q;
    logic [NUM_REQ-1:0] grant_mask;
    logic               tx_start_q, sent_q, overrun_q, timeout_q;
    logic [7:0]         tx_data_q;
    logic [7:0]         pick_byte;
    logic               pick_found;
    logic [2:0]         pick_idx;
    logic               do_grant, sent_d, timeout_d;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .pending (pending_q),
        .last    (last_q),
        .found   (pick_found),
        .next    (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_grant  = 1'b0;
        sent_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found && !bus.tx_busy) begin
                    do_grant = 1'b1;
                    cnt_d    = '0;
                    state_d  = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_LO;
                end else if (cnt_q >= CNT_W'(BUSY_WAIT_MAX - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LO: begin
                if (!bus.tx_busy) begin
                    sent_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_mask = '0;
        pick_byte  = 8'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_mask[i] = do_grant && (pick_idx == 3'(i));
            if (pick_idx == 3'(i)) pick_byte = hold_q[i];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= 3'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'd0;
            sent_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_start_q <= do_grant;
            sent_q     <= sent_d;
            timeout_q  <= timeout_d;
            if (do_grant) begin
                tx_data_q <= pick_byte;
                last_q    <= pick_idx;
            end
        end
    end

    // A req landing on its own grant edge refills the slot; that is not an overrun
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) hold_q[i] <= 8'd0;
        end else begin
            pending_q <= (pending_q & ~grant_mask) | bus.req;
            overrun_q <= |(bus.req & pending_q & ~grant_mask);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req[i]) hold_q[i] <= bus.req_data[8*i +: 8];
            end
        end
    end

    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.grant_id   = last_q;
    assign bus.pending    = pending_q;
    assign bus.sent       = sent_q;
    assign bus.overrun    = overrun_q;
    assign bus.tx_timeout = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized and directed bench for uart_tx_arbiter against a slot-level model
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int BWM = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_WAIT_MAX(BWM)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [N-1:0]   m_pend;
    logic [7:0]     m_val [N];
    int             m_last;
    logic           m_idle;
    logic [7:0]     m_data;
    logic [N-1:0]   req_prev;
    logic [8*N-1:0] data_prev;
    logic           busy_prev;
    int             rise_c, fall_c, exp_sent, exp_to;
    int             force_len;
    logic           force_to, rand_to, ext_en;
    int             obs_ov, obs_to, obs_sent;
    logic [7:0]     launch_log [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pend    = '0;
        for (int i = 0; i < N; i++) m_val[i] = 8'd0;
        m_last    = 0;
        m_idle    = 1'b1;
        m_data    = 8'd0;
        req_prev  = '0;
        data_prev = '0;
        busy_prev = 1'b0;
        rise_c    = -1;
        fall_c    = -1;
        exp_sent  = -1;
        exp_to    = -1;
    endtask

    // Checks the outputs produced by the edge just passed, then folds that edge's inputs into the model
    task automatic model_cycle();
        logic exp_start;
        logic ov;
        int   pick;
        int   len;
        exp_start = m_idle && (m_pend != '0) && !busy_prev;
        check("tx_start", {31'd0, bus.tx_start}, {31'd0, exp_start});
        if (exp_start) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                if (pick < 0 && m_pend[(m_last + k) % N]) pick = (m_last + k) % N;
            end
            check("grant_id", {29'd0, bus.grant_id}, pick);
            check("tx_data", {24'd0, bus.tx_data}, {24'd0, m_val[pick]});
            m_data       = m_val[pick];
            m_pend[pick] = 1'b0;
            m_last       = pick;
            m_idle       = 1'b0;
            launch_log.push_back(m_val[pick]);
            if (force_to || (rand_to && $urandom_range(0, 7) == 0)) begin
                exp_to   = cyc + BWM;
                exp_sent = -1;
                rise_c   = -1;
                fall_c   = -1;
                force_to = 1'b0;
            end else begin
                len      = (force_len > 0) ? force_len : int'($urandom_range(1, 8));
                rise_c   = cyc + 1;
                fall_c   = cyc + 1 + len;
                exp_sent = fall_c + 1;
                exp_to   = -1;
            end
        end else begin
            check("tx_data_hold", {24'd0, bus.tx_data}, {24'd0, m_data});
        end
        ov = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_prev[i]) begin
                if (m_pend[i]) ov = 1'b1;
                m_pend[i] = 1'b1;
                m_val[i]  = data_prev[8*i +: 8];
            end
        end
        check("overrun", {31'd0, bus.overrun}, {31'd0, ov});
        check("pending", {28'd0, bus.pending}, {28'd0, m_pend});
        check("sent", {31'd0, bus.sent}, (cyc == exp_sent) ? 1 : 0);
        check("tx_timeout", {31'd0, bus.tx_timeout}, (cyc == exp_to) ? 1 : 0);
        obs_ov   += int'(bus.overrun);
        obs_to   += int'(bus.tx_timeout);
        obs_sent += int'(bus.sent);
        if (cyc == exp_sent || cyc == exp_to) m_idle = 1'b1;
    endtask

    task automatic step(input logic [N-1:0] r, input logic [8*N-1:0] d);
        logic b;
        @(negedge clock);
        cyc++;
        model_cycle();
        b = (cyc >= rise_c && cyc < fall_c) || (ext_en && m_idle && $urandom_range(0, 7) == 0);
        bus.req      = r;
        bus.req_data = d;
        bus.tx_busy  = b;
        req_prev     = r;
        data_prev    = d;
        busy_prev    = b;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_start"}, {31'd0, bus.tx_start}, 0);
        check({tag, "_tx_data"}, {24'd0, bus.tx_data}, 0);
        check({tag, "_grant_id"}, {29'd0, bus.grant_id}, 0);
        check({tag, "_pending"}, {28'd0, bus.pending}, 0);
        check({tag, "_sent"}, {31'd0, bus.sent}, 0);
        check({tag, "_overrun"}, {31'd0, bus.overrun}, 0);
        check({tag, "_tx_timeout"}, {31'd0, bus.tx_timeout}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base, ov0, to0, snt0, guard;
        logic [N-1:0] r;
        logic [7:0] cont_exp [4];
        cont_exp = '{8'h42, 8'h43, 8'h44, 8'h41};

        bus.req = '0; bus.req_data = '0; bus.tx_busy = 1'b0;
        force_len = 0; force_to = 1'b0; rand_to = 1'b0; ext_en = 1'b0;
        obs_ov = 0; obs_to = 0; obs_sent = 0;
        model_reset();
        repeat (3) @(negedge clock);
        check_all_zero("rst");
        reset = 1'b1;

        // single request
        repeat (8) step('0, '0);
        force_len = 7; base = launch_log.size(); snt0 = obs_sent;
        step(4'b0001, {24'd0, 8'h33});
        repeat (15) step('0, '0);
        check("single_count", launch_log.size() - base, 1);
        if (launch_log.size() > 0) check("single_byte", {24'd0, launch_log[$]}, 32'h33);
        check("single_sent", obs_sent - snt0, 1);

        // all four at once after last grant 0: order 1,2,3,0
        force_len = 0; base = launch_log.size();
        step(4'b1111, {8'h44, 8'h43, 8'h42, 8'h41});
        repeat (70) step('0, '0);
        check("cont_count", launch_log.size() - base, 4);
        if (launch_log.size() >= base + 4)
            for (int k = 0; k < 4; k++) check("cont_order", {24'd0, launch_log[base+k]}, {24'd0, cont_exp[k]});
        check("cont_pending", {28'd0, bus.pending}, 0);

        // overrun while a byte is in flight
        force_len = 8; base = launch_log.size(); ov0 = obs_ov;
        step(4'b0001, {24'd0, 8'h01});
        repeat (3) step('0, '0);
        step(4'b0010, {16'd0, 8'h10, 8'h00});
        step(4'b0010, {16'd0, 8'h20, 8'h00});
        repeat (40) step('0, '0);
        check("ovr_pulses", obs_ov - ov0, 1);
        check("ovr_count", launch_log.size() - base, 2);
        if (launch_log.size() > 0) check("ovr_byte", {24'd0, launch_log[$]}, 32'h20);

        // timeout on first launch, second pending byte still goes out
        force_len = 0; force_to = 1'b1; to0 = obs_to; base = launch_log.size();
        step(4'b0101, {8'h00, 8'h45, 8'h00, 8'h44});
        repeat (50) step('0, '0);
        check("to_pulses", obs_to - to0, 1);
        check("to_count", launch_log.size() - base, 2);

        // req[2] on the very edge that grants requester 2
        force_len = 6; ov0 = obs_ov; base = launch_log.size();
        step(4'b0001, {24'd0, 8'h50});
        repeat (2) step('0, '0);
        step(4'b0100, {8'h00, 8'h55, 16'd0});
        guard = 0;
        while (cyc + 1 != exp_sent && guard < 60) begin
            step('0, '0);
            guard++;
        end
        check("coll_align", cyc + 1, exp_sent);
        step(4'b0100, {8'h00, 8'h66, 16'd0});
        repeat (40) step('0, '0);
        check("coll_overrun", obs_ov - ov0, 0);
        check("coll_count", launch_log.size() - base, 3);
        if (launch_log.size() >= 2) begin
            check("coll_first", {24'd0, launch_log[launch_log.size()-2]}, 32'h55);
            check("coll_second", {24'd0, launch_log[launch_log.size()-1]}, 32'h66);
        end

        // randomized traffic with external busy and random timeouts
        force_len = 0; ext_en = 1'b1; rand_to = 1'b1;
        repeat (1500) begin
            for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 9) == 0);
            step(r, {$urandom()});
        end
        ext_en = 1'b0; rand_to = 1'b0;
        repeat (100) step('0, '0);
        check("rand_drain", {28'd0, bus.pending}, 0);

        // reset while in WAIT_LO with two slots pending
        force_len = 10;
        step(4'b0001, {24'd0, 8'h11});
        repeat (2) step('0, '0);
        step(4'b0110, {8'h00, 8'h33, 8'h22, 8'h00});
        repeat (2) step('0, '0);
        check("pre_rst_pending", {28'd0, bus.pending}, 32'h6);
        #2 reset = 1'b0;
        #1 check_all_zero("async_rst");
        bus.req = '0; bus.req_data = '0; bus.tx_busy = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        model_reset();
        base = launch_log.size();
        repeat (20) step('0, '0);
        check("post_rst_quiet", launch_log.size() - base, 0);
        step(4'b0100, {8'h00, 8'h77, 16'd0});
        repeat (20) step('0, '0);
        check("post_rst_count", launch_log.size() - base, 1);
        check("post_rst_grant", {29'd0, bus.grant_id}, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
